// File: rtl/node_packet_sink.sv
// Ejection endpoint: accepts packets under an LFSR-paced enable and keeps per-phase statistics.
// Latency: every output is registered, so an accept in cycle t shows at t+1. Backpressure: data seen while o_en=0 is dropped and flagged.
package node_packet_sink_pkg;
    typedef struct packed {
        logic       ant;
        logic [3:0] x_dest;
        logic [3:0] y_dest;
    } packet_t;
endpackage

module node_packet_sink
    import node_packet_sink_pkg::*;
#(
    parameter int          X_LOC           = 0,
    parameter int          Y_LOC           = 0,
    parameter int          EN_RATE         = 100,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          WARMUP_PACKETS  = 1000,
    parameter int          MEASURE_PACKETS = 5000,
    parameter int          DRAIN_PACKETS   = 3000,
    parameter int          CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  packet_t          i_data,
    input  logic             i_data_val,
    output logic             o_en,
    input  logic             i_start,
    output logic [2:0]       o_phase,
    output logic             o_done,
    output logic [CNT_W-1:0] o_rx_count,
    output logic [CNT_W-1:0] o_meas_count,
    output logic [CNT_W-1:0] o_ant_count,
    output logic [CNT_W-1:0] o_misroute_count,
    output logic             o_misroute,
    output logic             o_protocol_err
);

    localparam int PH_MAX_A = (WARMUP_PACKETS > MEASURE_PACKETS) ? WARMUP_PACKETS : MEASURE_PACKETS;
    localparam int PH_MAX   = (PH_MAX_A > DRAIN_PACKETS) ? PH_MAX_A : DRAIN_PACKETS;
    localparam int PH_W     = (PH_MAX < 1) ? 1 : $clog2(PH_MAX + 1);
    localparam int THRESH   = (EN_RATE * 128) / 100;
    localparam logic [7:0] THRESH8 = 8'(THRESH);
    localparam logic [3:0] X_L = 4'(X_LOC);
    localparam logic [3:0] Y_L = 4'(Y_LOC);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WARMUP  = 3'd1,
        S_MEASURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              misroute_q, misroute_d;
    logic              perr_q, perr_d;
    logic [CNT_W-1:0]  rx_q, rx_d, meas_q, meas_d, ant_q, ant_d, mis_cnt_q, mis_cnt_d;

    logic              acc, active, cnt_acc, is_mis, rate_en, phase_end;
    logic [PH_W-1:0]   ph_target;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
        return v;
    endfunction

    always_comb begin
        acc       = i_data_val && en_q;
        active    = (state_q == S_WARMUP) || (state_q == S_MEASURE) || (state_q == S_DRAIN);
        cnt_acc   = acc && (state_q != S_IDLE);
        is_mis    = (i_data.x_dest != X_L) || (i_data.y_dest != Y_L);
        lfsr_d    = (state_q == S_IDLE) ? lfsr_q
                  : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        if (EN_RATE >= 100)   rate_en = 1'b1;
        else if (EN_RATE <= 0) rate_en = 1'b0;
        else                  rate_en = ({1'b0, lfsr_q[6:0]} < THRESH8);

        case (state_q)
            S_WARMUP:  ph_target = PH_W'(WARMUP_PACKETS);
            S_MEASURE: ph_target = PH_W'(MEASURE_PACKETS);
            S_DRAIN:   ph_target = PH_W'(DRAIN_PACKETS);
            default:   ph_target = '0;
        endcase
        // A zero-length phase ends on its first clock regardless of traffic.
        phase_end = active && ((ph_target == '0) || (acc && (ph_cnt_q + PH_W'(1) == ph_target)));

        state_d = state_q;
        case (state_q)
            S_IDLE:    if (i_start) state_d = S_WARMUP;
            S_WARMUP:  if (phase_end) state_d = S_MEASURE;
            S_MEASURE: if (phase_end) state_d = S_DRAIN;
            S_DRAIN:   if (phase_end) state_d = S_DONE;
            default:   state_d = state_q;
        endcase

        ph_cnt_d = ph_cnt_q;
        if (phase_end)         ph_cnt_d = '0;
        else if (active && acc) ph_cnt_d = ph_cnt_q + PH_W'(1);

        if (state_d == S_DONE)      en_d = 1'b1;
        else if (state_d == S_IDLE) en_d = 1'b0;
        else                        en_d = rate_en;

        done_d     = (state_d == S_DONE);
        rx_d       = sat_inc(rx_q, cnt_acc);
        meas_d     = sat_inc(meas_q, cnt_acc && (state_q == S_MEASURE) && (MEASURE_PACKETS != 0));
        ant_d      = sat_inc(ant_q, cnt_acc && i_data.ant);
        mis_cnt_d  = sat_inc(mis_cnt_q, cnt_acc && is_mis);
        misroute_d = cnt_acc && is_mis;
        perr_d     = perr_q || (i_data_val && !en_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            ph_cnt_q   <= '0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            misroute_q <= 1'b0;
            perr_q     <= 1'b0;
            rx_q       <= '0;
            meas_q     <= '0;
            ant_q      <= '0;
            mis_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            ph_cnt_q   <= ph_cnt_d;
            en_q       <= en_d;
            done_q     <= done_d;
            misroute_q <= misroute_d;
            perr_q     <= perr_d;
            rx_q       <= rx_d;
            meas_q     <= meas_d;
            ant_q      <= ant_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    assign o_en             = en_q;
    assign o_phase          = state_q;
    assign o_done           = done_q;
    assign o_rx_count       = rx_q;
    assign o_meas_count     = meas_q;
    assign o_ant_count      = ant_q;
    assign o_misroute_count = mis_cnt_q;
    assign o_misroute       = misroute_q;
    assign o_protocol_err   = perr_q;

endmodule

// File: tb/tb_node_packet_sink.sv
// Bench for node_packet_sink: four instances cover phase flow, misroute, rate, zero rate, saturation and reset.
module tb_node_packet_sink;
    import node_packet_sink_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_phase(input int n, input int w, input int m, input int d);
        if (n < w) return 1;
        if (n < w + m) return 2;
        if (n < w + m + d) return 3;
        return 4;
    endfunction

    function automatic int exp_meas(input int n, input int w, input int m);
        if (n <= w) return 0;
        if (n - w < m) return n - w;
        return m;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // A: phase flow and misroute, node (2,1), W/M/D = 4/6/3
    logic a_start, a_val, a_en, a_done, a_mis, a_perr;
    packet_t a_dat;
    logic [2:0] a_phase;
    logic [15:0] a_rx, a_meas, a_ant, a_mis_cnt;
    node_packet_sink #(.X_LOC(2), .Y_LOC(1), .EN_RATE(100), .WARMUP_PACKETS(4),
                       .MEASURE_PACKETS(6), .DRAIN_PACKETS(3), .CNT_W(16)) u_a (
        .clk(clk), .reset(rst), .i_data(a_dat), .i_data_val(a_val), .o_en(a_en),
        .i_start(a_start), .o_phase(a_phase), .o_done(a_done), .o_rx_count(a_rx),
        .o_meas_count(a_meas), .o_ant_count(a_ant), .o_misroute_count(a_mis_cnt),
        .o_misroute(a_mis), .o_protocol_err(a_perr));

    // B: 50% enable rate, phases too long to finish
    logic b_start, b_val, b_en, b_done, b_mis, b_perr;
    packet_t b_dat;
    logic [2:0] b_phase;
    logic [15:0] b_rx, b_meas, b_ant, b_mis_cnt;
    node_packet_sink #(.EN_RATE(50), .WARMUP_PACKETS(20000), .MEASURE_PACKETS(20000),
                       .DRAIN_PACKETS(20000), .CNT_W(16)) u_b (
        .clk(clk), .reset(rst), .i_data(b_dat), .i_data_val(b_val), .o_en(b_en),
        .i_start(b_start), .o_phase(b_phase), .o_done(b_done), .o_rx_count(b_rx),
        .o_meas_count(b_meas), .o_ant_count(b_ant), .o_misroute_count(b_mis_cnt),
        .o_misroute(b_mis), .o_protocol_err(b_perr));

    // Z: zero enable rate
    logic z_start, z_val, z_en, z_done, z_mis, z_perr;
    packet_t z_dat;
    logic [2:0] z_phase;
    logic [15:0] z_rx, z_meas, z_ant, z_mis_cnt;
    node_packet_sink #(.EN_RATE(0), .WARMUP_PACKETS(2), .MEASURE_PACKETS(2),
                       .DRAIN_PACKETS(2), .CNT_W(16)) u_z (
        .clk(clk), .reset(rst), .i_data(z_dat), .i_data_val(z_val), .o_en(z_en),
        .i_start(z_start), .o_phase(z_phase), .o_done(z_done), .o_rx_count(z_rx),
        .o_meas_count(z_meas), .o_ant_count(z_ant), .o_misroute_count(z_mis_cnt),
        .o_misroute(z_mis), .o_protocol_err(z_perr));

    // C: zero-length warmup, 3-bit counters to reach saturation
    logic c_start, c_val, c_en, c_done, c_mis, c_perr;
    packet_t c_dat;
    logic [2:0] c_phase;
    logic [2:0] c_rx, c_meas, c_ant, c_mis_cnt;
    node_packet_sink #(.EN_RATE(100), .WARMUP_PACKETS(0), .MEASURE_PACKETS(5),
                       .DRAIN_PACKETS(3), .CNT_W(3)) u_c (
        .clk(clk), .reset(rst), .i_data(c_dat), .i_data_val(c_val), .o_en(c_en),
        .i_start(c_start), .o_phase(c_phase), .o_done(c_done), .o_rx_count(c_rx),
        .o_meas_count(c_meas), .o_ant_count(c_ant), .o_misroute_count(c_mis_cnt),
        .o_misroute(c_mis), .o_protocol_err(c_perr));

    task automatic chk_a_reset(input string pfx);
        chk({pfx, "_en"}, a_en, 0);
        chk({pfx, "_phase"}, a_phase, 0);
        chk({pfx, "_done"}, a_done, 0);
        chk({pfx, "_rx"}, a_rx, 0);
        chk({pfx, "_meas"}, a_meas, 0);
        chk({pfx, "_ant"}, a_ant, 0);
        chk({pfx, "_mis_cnt"}, a_mis_cnt, 0);
        chk({pfx, "_mis"}, a_mis, 0);
        chk({pfx, "_perr"}, a_perr, 0);
    endtask

    initial begin
        int n, n_ant, n_mis, en_cnt;
        logic m, an;
        rst = 1'b1;
        a_start = 0; a_val = 0; a_dat = '0;
        b_start = 0; b_val = 0; b_dat = '0;
        z_start = 0; z_val = 0; z_dat = '0;
        c_start = 0; c_val = 0; c_dat = '0;
        #3;
        chk_a_reset("rst");
        tick();
        rst = 1'b0;
        tick();

        // C: one-cycle warmup, then saturating counters
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        chk("c_warm_phase", c_phase, 1);
        chk("c_warm_en", c_en, 1);
        tick();
        chk("c_meas_phase", c_phase, 2);
        chk("c_meas_zero", c_meas, 0);
        n = 0; n_ant = 0; n_mis = 0;
        for (int i = 0; i < 10; i++) begin
            an = 1'($urandom_range(1, 0));
            m  = 1'($urandom_range(3, 0) == 0);
            c_dat = '{ant: an, x_dest: (m ? 4'd1 : 4'd0), y_dest: 4'd0};
            c_val = 1'b1;
            chk("c_en", c_en, 1);
            tick();
            n++; n_ant += an; n_mis += m;
            chk("c_phase", c_phase, exp_phase(n, 0, 5, 3));
            chk("c_rx", c_rx, sat(n, 7));
            chk("c_meas", c_meas, sat(exp_meas(n, 0, 5), 7));
            chk("c_ant", c_ant, sat(n_ant, 7));
            chk("c_mis_cnt", c_mis_cnt, sat(n_mis, 7));
            chk("c_done", c_done, (n >= 8));
        end
        c_val = 1'b0;

        // Z: data in IDLE and at zero rate is never counted
        z_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("z_idle_en", z_en, 0);
            chk("z_idle_rx", z_rx, 0);
            chk("z_idle_phase", z_phase, 0);
        end
        chk("z_idle_perr", z_perr, 1);
        z_start = 1'b1;
        tick();
        z_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("z_en", z_en, 0);
            chk("z_rx", z_rx, 0);
            chk("z_phase", z_phase, 1);
        end
        z_val = 1'b0;

        // B: half-rate backpressure
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_dat = '{ant: 1'b0, x_dest: 4'd0, y_dest: 4'd0};
        b_val = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            if (b_en) en_cnt++;
            tick();
        end
        b_val = 1'b0;
        chk("b_rx_vs_en", b_rx, en_cnt);
        chk("b_rate_window", (en_cnt >= 4500 && en_cnt <= 5500), 1);
        chk("b_perr", b_perr, 1);
        chk("b_phase", b_phase, 1);

        // A: never started so far
        chk("a_idle_en", a_en, 0);
        chk("a_idle_phase", a_phase, 0);
        chk("a_idle_rx", a_rx, 0);

        // A: full phase sequence with misroutes
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("a_start_phase", a_phase, 1);
        n = 0; n_ant = 0; n_mis = 0;
        for (int i = 0; i < 16; i++) begin
            an = 1'($urandom_range(1, 0));
            if (i < 5) m = (i == 1 || i == 3);
            else       m = 1'($urandom_range(3, 0) == 0);
            a_dat = '{ant: an, x_dest: (m ? 4'd0 : 4'd2), y_dest: 4'd1};
            a_val = 1'b1;
            chk("a_en", a_en, 1);
            tick();
            n++; n_ant += an; n_mis += m;
            chk("a_phase", a_phase, exp_phase(n, 4, 6, 3));
            chk("a_rx", a_rx, n);
            chk("a_meas", a_meas, exp_meas(n, 4, 6));
            chk("a_ant", a_ant, n_ant);
            chk("a_mis_cnt", a_mis_cnt, n_mis);
            chk("a_mis_pulse", a_mis, m);
            chk("a_done", a_done, (n >= 13));
            chk("a_perr", a_perr, 0);
            if (i == 4) chk("a_mis_after5", a_mis_cnt, 2);
        end
        a_val = 1'b0;
        tick();
        chk("a_mis_pulse_end", a_mis, 0);
        chk("a_final_meas", a_meas, 6);
        chk("a_final_rx", a_rx, 16);

        // A: asynchronous reset while in MEASURE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_dat = '{ant: 1'b1, x_dest: 4'd0, y_dest: 4'd1};
        a_val = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        a_val = 1'b0;
        chk("a_pre_rst_phase", a_phase, 2);
        chk("a_pre_rst_rx", a_rx, 6);
        #3;
        rst = 1'b1;
        #1;
        chk_a_reset("async");
        tick();
        chk("async_hold_phase", a_phase, 0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/node_packet_sink.md
# node_packet_sink

Ejection-side endpoint for one mesh node: consumes packets leaving the network on a node output port, drives that port's downstream enable from a programmable-rate LFSR, checks each packet's destination against the node's own coordinates, and keeps warm-up / measure / drain statistics. One instance per node sits on the network's `o_data`/`o_data_val`/`i_en` bus. It is the receive-side counterpart of the per-node injection FIFOs.

## Interface
Parameters:
- `X_LOC`, default 0: this node's x coordinate, compared against `x_dest`.
- `Y_LOC`, default 0: this node's y coordinate, compared against `y_dest`.
- `EN_RATE`, default 100: percent of cycles `o_en` is high, range 0..100.
- `LFSR_SEED`, default 16'hACE1: nonzero seed for the enable LFSR.
- `WARMUP_PACKETS`, default 1000: accepted packets in the WARMUP phase.
- `MEASURE_PACKETS`, default 5000: accepted packets in the MEASURE phase.
- `DRAIN_PACKETS`, default 3000: accepted packets in the DRAIN phase.
- `CNT_W`, default 32: width of all statistic counters.

Ports:
- `clk`, in, 1: clock. One clock; reset is asynchronous and active-high.
- `reset`, in, 1: asynchronous, active-high reset.
- `i_data`, in, `packet_t`: packet from the network node output.
- `i_data_val`, in, 1: `i_data` valid.
- `o_en`, out, 1: downstream enable to the network (network `i_en[node]`).
- `i_start`, in, 1: leave IDLE. Sampled only in IDLE.
- `o_phase`, out, 3: 0 IDLE, 1 WARMUP, 2 MEASURE, 3 DRAIN, 4 DONE.
- `o_done`, out, 1: high in DONE.
- `o_rx_count`, out, `CNT_W`: all accepted packets.
- `o_meas_count`, out, `CNT_W`: packets accepted in MEASURE.
- `o_ant_count`, out, `CNT_W`: accepted packets with `ant`=1.
- `o_misroute_count`, out, `CNT_W`: accepted packets whose destination is not (`X_LOC`,`Y_LOC`).
- `o_misroute`, out, 1: one-cycle pulse, one per misrouted accept.
- `o_protocol_err`, out, 1: sticky flag; set when `i_data_val`=1 while `o_en`=0.

## Operation
- Accept: `acc = i_data_val && o_en`, using the registered `o_en` of the same cycle. Nothing is counted when `acc`=0.
- Enable generation:
  - 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed `LFSR_SEED`. It advances every cycle outside IDLE.
  - `THRESH = (EN_RATE*128)/100` is computed at elaboration.
  - Next `o_en = (lfsr[6:0] < THRESH)`.
  - `EN_RATE`=100 forces `o_en`=1 and `EN_RATE`=0 forces `o_en`=0, regardless of the LFSR.
  - `o_en` is held at 0 in IDLE and forced to 1 in DONE.
- FSM:
  - IDLE -> WARMUP when `i_start`=1.
  - WARMUP -> MEASURE, MEASURE -> DRAIN and DRAIN -> DONE when the phase counter reaches that phase's packet count.
  - DONE is terminal until reset.
- Phase counter:
  - Increments on `acc` and clears on every transition.
  - The transition happens on the clock edge of the accept that makes the count equal N. That packet belongs to the old phase.
  - A phase with N=0 is left on the first clock after entry, with no packet attributed to it.
- Counters:
  - `o_rx_count` increments on every `acc` in any non-IDLE phase, including DONE.
  - `o_meas_count` increments on `acc` only while in MEASURE.
  - `o_ant_count` increments on `acc && ant`.
  - `o_misroute_count` increments on `acc && (x_dest != X_LOC || y_dest != Y_LOC)`.
  - All counters saturate at all-ones and never wrap.
- Errors:
  - `o_protocol_err` is set on `i_data_val && !o_en` and cleared only by reset.
  - A packet presented this way is not counted.

## Timing
- Reset values: `o_en`=0, `o_phase`=0, `o_done`=0, all counts 0, `o_misroute`=0, `o_protocol_err`=0, LFSR=`LFSR_SEED`.
- Reset asserted mid-run returns everything to the reset values on the same edge and discards any in-flight statistics.
- All outputs are registered.
- An accept in cycle t is visible in the counters, `o_misroute` and `o_phase` at t+1.
- `i_start` sampled at edge t gives `o_phase`=1 at t+1. The first LFSR-derived `o_en` appears at t+1.
- `o_en` is registered. Network logic must treat the enable of cycle t as valid for the data of cycle t.
- Simultaneous accept and phase boundary: counters attribute the packet to the old phase. For example, the last MEASURE packet increments `o_meas_count`.
- Saturation: a counter at all-ones stays at all-ones on further accepts. The FSM still advances, because phase counters are sized separately to `$clog2(max N + 1)`.

## Test plan
- Phase sequence:
  - Stimulus: `EN_RATE`=100, W/M/D = 4/6/3, `i_start` pulse, then `i_data_val`=1 every cycle with the correct destination.
  - Response: `o_phase` steps 1->2->3->4 at 4, 10 and 13 accepted packets. Final `o_meas_count`=6, `o_rx_count`=13, `o_done`=1.
- Misroute:
  - Stimulus: `X_LOC`=2, `Y_LOC`=1, five packets, two of them with `x_dest`=0.
  - Response: `o_misroute_count`=2, and exactly two one-cycle `o_misroute` pulses, each one cycle after its accept.
- Backpressure:
  - Stimulus: `EN_RATE`=50, 10000 cycles, `i_data_val` held high.
  - Response: `o_rx_count` equals the number of cycles with `o_en`=1, within 45-55% of 10000. `o_protocol_err`=1.
- Zero rate and IDLE:
  - Stimulus: `EN_RATE`=0 after start, or no `i_start`.
  - Response: `o_en` stays 0 and all counts stay 0.
- Ants and zero-length phase:
  - Stimulus: `WARMUP_PACKETS`=0, three packets with `ant`=1 among eight.
  - Response: WARMUP lasts one cycle, and `o_ant_count`=3.
- Mid-run reset:
  - Stimulus: assert `reset` asynchronously in MEASURE.
  - Response: all outputs return to their reset values immediately, without waiting for a clock edge, and `o_phase`=0.
